// File: rtl/p405s_utlb_pkg.sv
// Shared widths, page-size and attribute encodings, and packed tag/data layouts for the unified TLB.
// The entry widths live here so that tag_t/data_t and every port follow one definition.
package p405s_utlb_pkg;

  localparam int EPN_W = 22;
  localparam int RPN_W = 22;
  localparam int TID_W = 8;

  localparam logic [2:0] PG_1K   = 3'd0;
  localparam logic [2:0] PG_4K   = 3'd1;
  localparam logic [2:0] PG_16K  = 3'd2;
  localparam logic [2:0] PG_64K  = 3'd3;
  localparam logic [2:0] PG_256K = 3'd4;
  localparam logic [2:0] PG_1M   = 3'd5;
  localparam logic [2:0] PG_4M   = 3'd6;
  localparam logic [2:0] PG_16M  = 3'd7;

  localparam int ATTR_EX = 7;
  localparam int ATTR_WR = 6;
  localparam int ATTR_W  = 5;
  localparam int ATTR_I  = 4;
  localparam int ATTR_M  = 3;
  localparam int ATTR_G  = 2;
  localparam int ATTR_U0 = 1;
  localparam int ATTR_E  = 0;

  typedef struct packed {
    logic [EPN_W-1:0] epn;
    logic [2:0]       size;
    logic             v;
    logic [TID_W-1:0] tid;
  } tag_t;

  typedef struct packed {
    logic [RPN_W-1:0] rpn;
    logic [7:0]       attr;
    logic [3:0]       zsel;
  } data_t;

  // Each size step quadruples the page, so two more EPN LSBs drop out of the compare.
  function automatic logic [EPN_W-1:0] epn_mask(input logic [2:0] size);
    logic [EPN_W-1:0] m;
    for (int b = 0; b < EPN_W; b++) m[b] = (b >= 2 * int'(size));
    return m;
  endfunction

endpackage

// File: rtl/p405s_utlb_cam_entry.sv
// One TLB entry: tag/data storage with even parity, combinational match and parity check.
// Writes land at the clock edge; only V is reset, the payload keeps its last written value.
module p405s_utlb_cam_entry
  import p405s_utlb_pkg::*;
(
  input  logic             CB,
  input  logic             reset,
  input  logic             wr_en,
  input  tag_t             wr_tag,
  input  data_t            wr_data,
  input  logic             clr_v,
  input  logic [EPN_W-1:0] lkp_epn,
  input  logic [TID_W-1:0] lkp_tid,
  output logic             hit,
  output logic             par_ok,
  output tag_t             tag,
  output data_t            data
);

  logic             v_q;
  logic [EPN_W-1:0] epn_q;
  logic [2:0]       size_q;
  logic [TID_W-1:0] tid_q;
  data_t            data_q;
  logic             tpar_q;
  logic             dpar_q;

  always_ff @(posedge CB or negedge reset) begin
    if (!reset)      v_q <= 1'b0;
    else if (wr_en)  v_q <= wr_tag.v;
    else if (clr_v)  v_q <= 1'b0;
  end

  // V is kept out of the tag parity so an invalidate never disturbs it.
  always_ff @(posedge CB) begin
    if (wr_en) begin
      epn_q  <= wr_tag.epn;
      size_q <= wr_tag.size;
      tid_q  <= wr_tag.tid;
      data_q <= wr_data;
      tpar_q <= ^{wr_tag.epn, wr_tag.size, wr_tag.tid};
      dpar_q <= ^wr_data;
    end
  end

  assign tag    = {epn_q, size_q, v_q, tid_q};
  assign data   = data_q;
  assign hit    = v_q && (((epn_q ^ lkp_epn) & epn_mask(size_q)) == '0) &&
                  ((tid_q == '0) || (tid_q == lkp_tid));
  assign par_ok = ~(^{epn_q, size_q, tid_q, tpar_q}) & ~(^{data_q, dpar_q});

endmodule

// File: rtl/p405s_utlb_gen2.sv
// Fully-associative unified TLB: one-cycle registered lookup/read, invalidate-all walk, round-robin victim.
// lkp_ready drops for the whole walk; responses and read data have no backpressure.
module p405s_utlb_gen2
  import p405s_utlb_pkg::*;
#(
  parameter int NUM_ENTRIES = 64,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic             CB,
  input  logic             reset,
  input  logic             lkp_valid,
  output logic             lkp_ready,
  input  logic [EPN_W-1:0] lkp_epn,
  input  logic [TID_W-1:0] lkp_tid,
  output logic             rsp_valid,
  output logic             rsp_miss,
  output logic             rsp_multi,
  output logic             rsp_par_err,
  output logic [IDX_W-1:0] rsp_index,
  output logic [RPN_W-1:0] rsp_rpn,
  output logic [7:0]       rsp_attr,
  output logic [3:0]       rsp_zsel,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [EPN_W-1:0] wr_epn,
  input  logic [2:0]       wr_size,
  input  logic             wr_v,
  input  logic [TID_W-1:0] wr_tid,
  input  logic [RPN_W-1:0] wr_rpn,
  input  logic [7:0]       wr_attr,
  input  logic [3:0]       wr_zsel,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_index,
  output logic             rd_valid,
  output tag_t             rd_tag,
  output data_t            rd_data,
  input  logic             inval_req,
  output logic             inval_busy,
  output logic             inval_done,
  output logic [IDX_W-1:0] victim_index
);

  typedef enum logic {S_IDLE, S_WALK} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       ptr;
  logic [NUM_ENTRIES-1:0] hit_vec, par_vec, wr_sel, clr_sel;
  tag_t                   tag_arr  [NUM_ENTRIES];
  data_t                  data_arr [NUM_ENTRIES];
  tag_t                   wr_tag;
  data_t                  wr_data, sel_data;
  logic [IDX_W-1:0]       sel;
  logic                   any_hit, multi, clean, wr_go, lkp_go;

  // An invalidate request or walk always wins over tlbwe in the same cycle.
  assign wr_go   = wr_en && (state == S_IDLE) && !inval_req;
  assign lkp_go  = lkp_valid && lkp_ready;
  assign wr_tag  = {wr_epn, wr_size, wr_v, wr_tid};
  assign wr_data = {wr_rpn, wr_attr, wr_zsel};

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_ent
    assign wr_sel[i]  = wr_go && (wr_index == IDX_W'(i));
    assign clr_sel[i] = (state == S_WALK) && (ptr == IDX_W'(i));
    p405s_utlb_cam_entry u_ent (
      .CB(CB), .reset(reset), .wr_en(wr_sel[i]), .wr_tag(wr_tag), .wr_data(wr_data),
      .clr_v(clr_sel[i]), .lkp_epn(lkp_epn), .lkp_tid(lkp_tid), .hit(hit_vec[i]),
      .par_ok(par_vec[i]), .tag(tag_arr[i]), .data(data_arr[i])
    );
  end

  always_comb begin
    sel     = '0;
    any_hit = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        sel     = IDX_W'(i);
        any_hit = 1'b1;
      end
    end
  end

  assign multi    = |(hit_vec & (hit_vec - NUM_ENTRIES'(1)));
  assign sel_data = data_arr[sel];
  assign clean    = any_hit && par_vec[sel];

  always_ff @(posedge CB or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      ptr          <= '0;
      lkp_ready    <= 1'b1;
      inval_busy   <= 1'b0;
      inval_done   <= 1'b0;
      victim_index <= '0;
    end else begin
      inval_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (inval_req) begin
            state      <= S_WALK;
            ptr        <= '0;
            lkp_ready  <= 1'b0;
            inval_busy <= 1'b1;
          end else if (wr_en && (wr_index == victim_index)) begin
            victim_index <= victim_index + IDX_W'(1);
          end
        end
        S_WALK: begin
          ptr <= ptr + IDX_W'(1);
          if (ptr == IDX_W'(NUM_ENTRIES - 1)) begin
            state        <= S_IDLE;
            lkp_ready    <= 1'b1;
            inval_busy   <= 1'b0;
            inval_done   <= 1'b1;
            victim_index <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CB or negedge reset) begin
    if (!reset) begin
      rsp_valid   <= 1'b0;
      rsp_miss    <= 1'b0;
      rsp_multi   <= 1'b0;
      rsp_par_err <= 1'b0;
      rsp_index   <= '0;
      rsp_rpn     <= '0;
      rsp_attr    <= '0;
      rsp_zsel    <= '0;
      rd_valid    <= 1'b0;
      rd_tag      <= '0;
      rd_data     <= '0;
    end else begin
      rsp_valid <= lkp_go;
      rd_valid  <= rd_en;
      if (lkp_go) begin
        rsp_multi   <= multi;
        rsp_par_err <= any_hit && !par_vec[sel];
        rsp_miss    <= !clean;
        rsp_index   <= sel;
        rsp_rpn     <= clean ? sel_data.rpn  : '0;
        rsp_attr    <= clean ? sel_data.attr : '0;
        rsp_zsel    <= clean ? sel_data.zsel : '0;
      end
      if (rd_en) begin
        rd_tag  <= tag_arr[rd_index];
        rd_data <= data_arr[rd_index];
      end
    end
  end

endmodule

// File: tb/tb_p405s_utlb_gen2.sv
// Directed bench for p405s_utlb_gen2: a behavioural TLB model checked every cycle plus literal expectations.
module tb_p405s_utlb_gen2;
  import p405s_utlb_pkg::*;

  localparam int N  = 64;
  localparam int IW = 6;

  logic             CB = 1'b0, reset = 1'b0;
  logic             lkp_valid = 1'b0, lkp_ready;
  logic [EPN_W-1:0] lkp_epn = '0;
  logic [TID_W-1:0] lkp_tid = '0;
  logic             rsp_valid, rsp_miss, rsp_multi, rsp_par_err;
  logic [IW-1:0]    rsp_index;
  logic [RPN_W-1:0] rsp_rpn;
  logic [7:0]       rsp_attr;
  logic [3:0]       rsp_zsel;
  logic             wr_en = 1'b0, wr_v = 1'b0;
  logic [IW-1:0]    wr_index = '0, rd_index = '0;
  logic [EPN_W-1:0] wr_epn = '0;
  logic [2:0]       wr_size = '0;
  logic [TID_W-1:0] wr_tid = '0;
  logic [RPN_W-1:0] wr_rpn = '0;
  logic [7:0]       wr_attr = '0;
  logic [3:0]       wr_zsel = '0;
  logic             rd_en = 1'b0, rd_valid;
  tag_t             rd_tag;
  data_t            rd_data;
  logic             inval_req = 1'b0, inval_busy, inval_done;
  logic [IW-1:0]    victim_index;

  p405s_utlb_gen2 #(.NUM_ENTRIES(N)) dut (
    .CB(CB), .reset(reset), .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_epn(lkp_epn),
    .lkp_tid(lkp_tid), .rsp_valid(rsp_valid), .rsp_miss(rsp_miss), .rsp_multi(rsp_multi),
    .rsp_par_err(rsp_par_err), .rsp_index(rsp_index), .rsp_rpn(rsp_rpn), .rsp_attr(rsp_attr),
    .rsp_zsel(rsp_zsel), .wr_en(wr_en), .wr_index(wr_index), .wr_epn(wr_epn), .wr_size(wr_size),
    .wr_v(wr_v), .wr_tid(wr_tid), .wr_rpn(wr_rpn), .wr_attr(wr_attr), .wr_zsel(wr_zsel),
    .rd_en(rd_en), .rd_index(rd_index), .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_data(rd_data),
    .inval_req(inval_req), .inval_busy(inval_busy), .inval_done(inval_done),
    .victim_index(victim_index)
  );

  always #5 CB = ~CB;

  int checks = 0, errors = 0;
  logic run = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: plain arrays, a walk countdown and a victim counter.
  logic             m_v [N];
  logic [EPN_W-1:0] m_epn [N];
  logic [2:0]       m_size [N];
  logic [TID_W-1:0] m_tid [N];
  logic [RPN_W-1:0] m_rpn [N];
  logic [7:0]       m_attr [N];
  logic [3:0]       m_zsel [N];
  logic             m_bad [N];
  int               m_walk_left = 0, m_victim = 0;
  logic             e_rsp_vld = 1'b0, e_rd_vld = 1'b0, e_done = 1'b0;
  logic             e_miss, e_multi, e_par;
  int               e_cnt, e_idx;
  logic [RPN_W-1:0] e_rpn;
  logic [7:0]       e_attr;
  logic [3:0]       e_zsel;
  logic [33:0]      e_rd_tag, e_rd_data;

  always @(posedge CB or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) m_v[i] = 1'b0;
      m_walk_left = 0; m_victim = 0;
      e_rsp_vld = 1'b0; e_rd_vld = 1'b0; e_done = 1'b0;
    end else begin
      e_rsp_vld = lkp_valid && (m_walk_left == 0);
      if (e_rsp_vld) begin
        e_cnt = 0; e_idx = 0;
        for (int i = N - 1; i >= 0; i--)
          if (m_v[i] && ((m_epn[i] >> (2 * m_size[i])) == (lkp_epn >> (2 * m_size[i]))) &&
              (m_tid[i] == 0 || m_tid[i] == lkp_tid)) begin
            e_cnt++; e_idx = i;
          end
        e_multi = (e_cnt > 1);
        e_par   = (e_cnt > 0) && m_bad[e_idx];
        e_miss  = (e_cnt == 0) || e_par;
        e_rpn   = e_miss ? '0 : m_rpn[e_idx];
        e_attr  = e_miss ? '0 : m_attr[e_idx];
        e_zsel  = e_miss ? '0 : m_zsel[e_idx];
      end
      e_rd_vld = rd_en;
      if (rd_en) begin
        e_rd_tag  = {m_epn[rd_index], m_size[rd_index], m_v[rd_index], m_tid[rd_index]};
        e_rd_data = {m_rpn[rd_index], m_attr[rd_index], m_zsel[rd_index]};
      end
      e_done = 1'b0;
      if (m_walk_left > 0) begin
        m_v[N - m_walk_left] = 1'b0;
        m_walk_left--;
        if (m_walk_left == 0) begin e_done = 1'b1; m_victim = 0; end
      end else if (inval_req) begin
        m_walk_left = N;
      end else if (wr_en) begin
        m_v[wr_index] = wr_v;       m_epn[wr_index] = wr_epn;   m_size[wr_index] = wr_size;
        m_tid[wr_index] = wr_tid;   m_rpn[wr_index] = wr_rpn;   m_attr[wr_index] = wr_attr;
        m_zsel[wr_index] = wr_zsel; m_bad[wr_index] = 1'b0;
        if (int'(wr_index) == m_victim) m_victim = (m_victim + 1) % N;
      end
    end
  end

  always @(negedge CB) begin
    if (run) begin
      chk("lkp_ready", 64'(lkp_ready), 64'(m_walk_left == 0));
      chk("inval_busy", 64'(inval_busy), 64'(m_walk_left > 0));
      chk("inval_done", 64'(inval_done), 64'(e_done));
      chk("victim", 64'(victim_index), 64'(m_victim));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp_vld));
      chk("rd_valid", 64'(rd_valid), 64'(e_rd_vld));
      if (e_rsp_vld) begin
        chk("rsp_miss", 64'(rsp_miss), 64'(e_miss));
        chk("rsp_multi", 64'(rsp_multi), 64'(e_multi));
        chk("rsp_par_err", 64'(rsp_par_err), 64'(e_par));
        if (e_cnt > 0) chk("rsp_index", 64'(rsp_index), 64'(e_idx));
        if (!e_miss || e_par) begin
          chk("rsp_rpn", 64'(rsp_rpn), 64'(e_rpn));
          chk("rsp_attr", 64'(rsp_attr), 64'(e_attr));
          chk("rsp_zsel", 64'(rsp_zsel), 64'(e_zsel));
        end
      end
      if (e_rd_vld) begin
        chk("rd_tag", 64'(rd_tag), 64'(e_rd_tag));
        chk("rd_data", 64'(rd_data), 64'(e_rd_data));
      end
    end
  end

  task automatic wr(input int idx, input logic [EPN_W-1:0] epn, input logic [2:0] sz,
                    input logic [TID_W-1:0] tid, input logic [RPN_W-1:0] rpn,
                    input logic [7:0] attr, input logic [3:0] zs);
    wr_en = 1'b1; wr_index = IW'(idx); wr_epn = epn; wr_size = sz; wr_v = 1'b1;
    wr_tid = tid; wr_rpn = rpn; wr_attr = attr; wr_zsel = zs;
    @(negedge CB);
    wr_en = 1'b0;
  endtask

  task automatic lk(input logic [EPN_W-1:0] epn, input logic [TID_W-1:0] tid);
    lkp_valid = 1'b1; lkp_epn = epn; lkp_tid = tid;
    @(negedge CB);
    lkp_valid = 1'b0;
  endtask

  task automatic rd(input int idx);
    rd_en = 1'b1; rd_index = IW'(idx);
    @(negedge CB);
    rd_en = 1'b0;
  endtask

  data_t bad;
  int    busy_n;

  initial begin
    repeat (3) @(negedge CB);
    #1 reset = 1'b1;
    @(negedge CB);
    run = 1'b1;
    chk("rst_lkp_ready", 64'(lkp_ready), 64'd1);
    chk("rst_busy", 64'(inval_busy), 64'd0);
    chk("rst_victim", 64'(victim_index), 64'd0);
    chk("rst_rsp", 64'({rsp_valid, rsp_miss, rsp_multi, rsp_par_err, rd_valid, inval_done}), 64'd0);

    wr(5, 22'h00400, 3'd1, 8'h12, 22'h3ABCD, 8'h81, 4'h6);
    lk(22'h00403, 8'h12);
    chk("hit_valid", 64'(rsp_valid), 64'd1);
    chk("hit_miss", 64'(rsp_miss), 64'd0);
    chk("hit_index", 64'(rsp_index), 64'd5);
    chk("hit_rpn", 64'(rsp_rpn), 64'h3ABCD);
    chk("hit_attr", 64'(rsp_attr), 64'h81);
    lk(22'h00403, 8'h13);
    chk("tid_miss", 64'(rsp_miss), 64'd1);

    wr(9, 22'h01000, 3'd0, 8'h00, 22'h00999, 8'h10, 4'h1);
    wr(2, 22'h01000, 3'd2, 8'h00, 22'h00222, 8'h20, 4'h2);
    lk(22'h01000, 8'h55);
    chk("multi_index", 64'(rsp_index), 64'd2);
    chk("multi_flag", 64'(rsp_multi), 64'd1);
    chk("multi_rpn", 64'(rsp_rpn), 64'h00222);
    lk(22'h01003, 8'h55);
    chk("single_multi", 64'(rsp_multi), 64'd0);

    rd(5);
    chk("rd5_tag", 64'(rd_tag), 64'({22'h00400, 3'd1, 1'b1, 8'h12}));

    wr(4, 22'h02000, 3'd0, 8'h00, 22'h15555, 8'h03, 4'h5);
    lk(22'h02000, 8'h99);
    chk("par_clean_rpn", 64'(rsp_rpn), 64'h15555);
    bad.rpn = 22'h15554; bad.attr = 8'h03; bad.zsel = 4'h5;
    force dut.g_ent[4].u_ent.data_q = bad;
    m_rpn[4] = 22'h15554; m_bad[4] = 1'b1;
    lk(22'h02000, 8'h99);
    chk("par_err", 64'(rsp_par_err), 64'd1);
    chk("par_miss", 64'(rsp_miss), 64'd1);
    chk("par_rpn0", 64'(rsp_rpn), 64'd0);
    rd(4);
    chk("par_rd_data", 64'(rd_data), 64'({22'h15554, 8'h03, 4'h5}));
    release dut.g_ent[4].u_ent.data_q;
    wr(4, 22'h02000, 3'd0, 8'h00, 22'h15555, 8'h03, 4'h5);
    lk(22'h02000, 8'h99);
    chk("par_fixed", 64'(rsp_par_err), 64'd0);

    lkp_valid = 1'b1; lkp_epn = 22'h00400; lkp_tid = 8'h12; inval_req = 1'b1;
    @(negedge CB);
    inval_req = 1'b0;
    busy_n = 0;
    for (int c = 0; c < 200 && inval_busy; c++) begin
      busy_n++;
      inval_req = (c == 3);
      wr_en = (c == 5);
      if (c == 5) begin
        wr_index = IW'(30); wr_epn = 22'h03000; wr_size = 3'd0; wr_v = 1'b1;
        wr_tid = 8'h00; wr_rpn = 22'h00333; wr_attr = 8'h01; wr_zsel = 4'h3;
      end
      @(negedge CB);
    end
    lkp_valid = 1'b0; inval_req = 1'b0; wr_en = 1'b0;
    chk("walk_len", 64'(busy_n), 64'd64);
    chk("walk_done", 64'(inval_done), 64'd1);
    @(negedge CB);
    lk(22'h00400, 8'h12);
    chk("post_walk_miss", 64'(rsp_miss), 64'd1);
    lk(22'h03000, 8'h00);
    chk("walk_wr_ignored", 64'(rsp_miss), 64'd1);
    chk("walk_victim0", 64'(victim_index), 64'd0);

    wr(0, 22'h04000, 3'd0, 8'h00, 22'h00040, 8'h04, 4'h0);
    wr(1, 22'h04400, 3'd0, 8'h00, 22'h00044, 8'h04, 4'h1);
    wr(2, 22'h04800, 3'd0, 8'h00, 22'h00048, 8'h04, 4'h2);
    chk("victim3", 64'(victim_index), 64'd3);
    wr(7, 22'h05000, 3'd0, 8'h00, 22'h00050, 8'h04, 4'h7);
    chk("victim_hold", 64'(victim_index), 64'd3);
    lk(22'h04400, 8'h01);
    chk("v_hit_index", 64'(rsp_index), 64'd1);

    inval_req = 1'b1;
    @(negedge CB);
    inval_req = 1'b0;
    repeat (10) @(negedge CB);
    #1 reset = 1'b0;
    @(negedge CB);
    chk("mid_rst_busy", 64'(inval_busy), 64'd0);
    chk("mid_rst_ready", 64'(lkp_ready), 64'd1);
    chk("mid_rst_done", 64'(inval_done), 64'd0);
    #1 reset = 1'b1;
    @(negedge CB);
    lk(22'h05000, 8'h00);
    chk("mid_rst_miss", 64'(rsp_miss), 64'd1);
    rd(1);
    chk("mid_rst_v", 64'(rd_tag.v), 64'd0);
    repeat (2) @(negedge CB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
